// File: rtl/noc_ingress_arbiter.sv
// -----------------------------------------------------------------------------
// noc_ingress_arbiter
//
// Shares one HNoC PE ingress port among NUM_REQ local requesters. A
// round-robin arbiter picks at most one requester per cycle and loads its
// packet into a single registered output slot. This gives one cycle of
// latency and up to one packet per cycle. A drain and a new load can happen
// in the same cycle, so back-to-back transfers have no bubble.
//
// An optional injection quota (PKT_LIMIT) bounds the total number of packets
// the cluster may inject. When the quota is reached, o_done rises and stays
// high until reset. After that no further packets are accepted. The last
// packet still drains normally. PKT_LIMIT = 0 means unlimited.
//
// Build option (macro ARB_PKT_COUNT_EN):
//   defined   : adds output o_pkt_count[31:0] with the accepted-packet count.
//   undefined : no o_pkt_count port. The internal counter is only as wide as
//               the quota compare needs.
//
// Parameters
//   NUM_REQ    number of requesters (2..16)
//   DATA_W     payload width
//   ADDR_W     destination address width; packet = {addr, data}
//   TOTAL_W    packet width (DATA_W + ADDR_W)
//   PKT_LIMIT  packets accepted before o_done; 0 = unlimited
//
// Ports
//   clk100       in   100 MHz clock
//   rst          in   synchronous, active-high reset
//   i_req_data   in   requester k packet at [k*TOTAL_W +: TOTAL_W]
//   i_req_valid  in   requester k has a packet
//   o_req_ready  out  one-hot or zero; requester k's packet accepted this cycle
//   o_noc_data   out  packet presented to the HNoC ingress
//   o_noc_valid  out  o_noc_data is valid
//   i_noc_ready  in   HNoC ingress accepts the packet this cycle
//   o_grant_id   out  requester whose packet occupies the slot
//   o_done       out  quota reached (sticky until reset)
//   o_pkt_count  out  accepted-packet count (only with ARB_PKT_COUNT_EN)
// -----------------------------------------------------------------------------
module noc_ingress_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 2,
  parameter int TOTAL_W   = DATA_W + ADDR_W,
  parameter int PKT_LIMIT = 100
) (
  input  logic                       clk100,
  input  logic                       rst,
  input  logic [NUM_REQ*TOTAL_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [TOTAL_W-1:0]         o_noc_data,
  output logic                       o_noc_valid,
  input  logic                       i_noc_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_done
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [31:0]                o_pkt_count
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  // When the count is exported, it is a full 32-bit counter that wraps in
  // unlimited mode. Otherwise it only needs to reach PKT_LIMIT.
`ifdef ARB_PKT_COUNT_EN
  localparam int CNT_W = 32;
`else
  localparam int CNT_W = (PKT_LIMIT == 0)              ? 1 :
                         ($clog2(PKT_LIMIT + 1) < 1)   ? 1 :
                         $clog2(PKT_LIMIT + 1);
`endif

  // Count value just before the final acceptance of the quota.
  localparam logic [CNT_W-1:0] LAST_CNT = (PKT_LIMIT == 0) ? '0 : CNT_W'(PKT_LIMIT - 1);

  logic [ID_W-1:0]    ptr;          // highest-priority requester this cycle
  logic [ID_W-1:0]    pick_id;      // winner of the round-robin search
  logic               pick_found;
  logic [ID_W-1:0]    ptr_next;     // requester after the winner, modulo NUM_REQ
  logic [TOTAL_W-1:0] pick_data;
  logic               slot_free;
  logic               accept;
  logic               last_accept;
  logic [CNT_W-1:0]   count;

  // The slot can take a new packet if it is empty or is draining this cycle.
  assign slot_free = !o_noc_valid || i_noc_ready;

  // Round-robin search: scan ptr, ptr+1, ... with wrap-around and take the
  // first valid requester. The index sum is one bit wider than the id, so the
  // wrap is a single conditional subtract. This also works for NUM_REQ values
  // that are not powers of two.
  always_comb begin
    logic [ID_W:0] idx_wide;
    logic [ID_W-1:0] idx;
    // NOTE: every variable driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    pick_found = 1'b0;
    pick_id    = '0;
    idx_wide   = '0;
    idx        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_wide = {1'b0, ptr} + (ID_W+1)'(off);
      if (idx_wide >= (ID_W+1)'(NUM_REQ)) begin
        idx_wide = idx_wide - (ID_W+1)'(NUM_REQ);
      end
      idx = idx_wide[ID_W-1:0];
      if (!pick_found && i_req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign pick_data = i_req_data[int'(pick_id)*TOTAL_W +: TOTAL_W];
  assign ptr_next  = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);

  // Reset gates acceptance so no requester sees a handshake while rst is
  // high. A done arbiter accepts nothing until the next reset.
  assign accept = !rst && slot_free && !o_done && pick_found;

  // The final acceptance of the quota is the one taken when the count sits
  // one below the limit.
  assign last_accept = (PKT_LIMIT != 0) && (count == LAST_CNT);

  always_comb begin
    o_req_ready = '0;
    if (accept) begin
      o_req_ready[pick_id] = 1'b1;
    end
  end

  // One register slot. If a packet is accepted, it replaces the current one.
  // The outgoing packet is either empty or draining this cycle (slot_free).
  // If nothing is accepted, the slot empties on a drain and otherwise holds
  // steady.
  always_ff @(posedge clk100) begin
    if (rst) begin
      // NOTE: the data register is reset as well, so a packet held at reset
      // time leaves no trace on o_noc_data.
      o_noc_valid <= 1'b0;
      o_noc_data  <= '0;
      o_grant_id  <= '0;
      o_done      <= 1'b0;
      ptr         <= '0;
      count       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // right-hand side below sees pre-edge values.
      if (accept) begin
        o_noc_valid <= 1'b1;
        o_noc_data  <= pick_data;
        o_grant_id  <= pick_id;
        ptr         <= ptr_next;
        count       <= count + CNT_W'(1);
        if (last_accept) begin
          o_done <= 1'b1;
        end
      end else if (i_noc_ready) begin
        o_noc_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_PKT_COUNT_EN
  assign o_pkt_count = count;
`endif

endmodule

// File: tb/tb_noc_ingress_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_ingress_arbiter
//
// Drives two arbiters from shared inputs: one with PKT_LIMIT = 10 and one with
// PKT_LIMIT = 100. A cycle-level reference model follows each arbiter from
// the behavioural rules: rotating priority, one registered slot, and the
// quota. Each cycle the model is compared with the ready, valid, data, grant,
// done and (optionally) count outputs.
//
// Directed phases cover the following:
//   - round-robin order
//   - output hold under backpressure
//   - quota stop
//   - wrap-around priority
//   - reset of a full slot
// A randomized phase then checks per-requester ordering with a scoreboard.
// -----------------------------------------------------------------------------
module tb_noc_ingress_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 2;
  localparam int TOTAL_W = DATA_W + ADDR_W;
  localparam int ID_W    = 2;

  logic clk100 = 1'b0;
  logic rst    = 1'b1;
  always #5 clk100 = ~clk100;

  logic [NUM_REQ*TOTAL_W-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic                       noc_ready = 1'b0;

  // Index 0: PKT_LIMIT = 10, index 1: PKT_LIMIT = 100.
  logic [NUM_REQ-1:0] req_ready [2];
  logic [TOTAL_W-1:0] noc_data  [2];
  logic               noc_valid [2];
  logic [ID_W-1:0]    grant_id  [2];
  logic               done      [2];
`ifdef ARB_PKT_COUNT_EN
  logic [31:0]        pkt_count [2];
`endif

  noc_ingress_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TOTAL_W(TOTAL_W), .PKT_LIMIT(10)
  ) u_lim10 (
    .clk100      (clk100),
    .rst         (rst),
    .i_req_data  (req_data),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready[0]),
    .o_noc_data  (noc_data[0]),
    .o_noc_valid (noc_valid[0]),
    .i_noc_ready (noc_ready),
    .o_grant_id  (grant_id[0]),
    .o_done      (done[0])
`ifdef ARB_PKT_COUNT_EN
    ,
    .o_pkt_count (pkt_count[0])
`endif
  );

  noc_ingress_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TOTAL_W(TOTAL_W), .PKT_LIMIT(100)
  ) u_lim100 (
    .clk100      (clk100),
    .rst         (rst),
    .i_req_data  (req_data),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready[1]),
    .o_noc_data  (noc_data[1]),
    .o_noc_valid (noc_valid[1]),
    .i_noc_ready (noc_ready),
    .o_grant_id  (grant_id[1]),
    .o_done      (done[1])
`ifdef ARB_PKT_COUNT_EN
    ,
    .o_pkt_count (pkt_count[1])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per arbiter.
  int               m_ptr   [2];
  logic             m_valid [2];
  logic [TOTAL_W-1:0] m_data [2];
  int               m_id    [2];
  logic             m_done  [2];
  int unsigned      m_cnt   [2];

  // Bookkeeping.
  int               hs_cnt  [2];        // output handshakes seen since last reset
  int               seq_in  [NUM_REQ];  // next sequence number each requester offers
  int               seq_out [NUM_REQ];  // next sequence number expected at the output
  bit               sb_on = 1'b0;
  logic [NUM_REQ-1:0] last_ready1;

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_valid[u] = 1'b0; m_data[u] = '0; m_id[u] = 0;
      m_done[u] = 1'b0; m_cnt[u] = 0; hs_cnt[u] = 0;
    end
  end

  function automatic int limit_of(int u);
    return (u == 0) ? 10 : 100;
  endfunction

  // Packet tag: requester number in the upper data byte, sequence in the rest.
  function automatic logic [TOTAL_W-1:0] pkt(int k, int seq);
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    d = (DATA_W'(k) << 24) | DATA_W'(seq & 32'h00FF_FFFF);
    a = ADDR_W'(seq);
    return {a, d};
  endfunction

  task automatic check(input string tag, input int u, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, u, obs, exp);
    end
  endtask

  // Model: choose who the arbiter should accept at the coming edge, or -1.
  function automatic int model_pick(int u);
    int k;
    if (rst) return -1;
    if (m_valid[u] && !noc_ready) return -1;
    if (m_done[u]) return -1;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = (m_ptr[u] + off) % NUM_REQ;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_advance(input int u, input int k);
    if (rst) begin
      m_ptr[u] = 0; m_valid[u] = 1'b0; m_data[u] = '0; m_id[u] = 0;
      m_done[u] = 1'b0; m_cnt[u] = 0;
    end else if (k >= 0) begin
      m_data[u]  = req_data[k*TOTAL_W +: TOTAL_W];
      m_valid[u] = 1'b1;
      m_id[u]    = k;
      m_ptr[u]   = (k + 1) % NUM_REQ;
      m_cnt[u]   = m_cnt[u] + 1;
      if (m_cnt[u] == limit_of(u)) m_done[u] = 1'b1;
    end else if (noc_ready) begin
      m_valid[u] = 1'b0;
    end
  endtask

  // One clock cycle. The bench checks combinational ready and counts
  // handshakes at the falling edge. It then steps the model, and after the
  // rising edge it checks the registered outputs.
  task automatic cycle();
    int pk [2];
    int id;
    logic [NUM_REQ-1:0] exp_ready;
    @(negedge clk100);
    for (int u = 0; u < 2; u++) begin
      pk[u] = model_pick(u);
      exp_ready = '0;
      if (pk[u] >= 0) exp_ready[pk[u]] = 1'b1;
      check("req_ready", u, 64'(req_ready[u]), 64'(exp_ready));
      if (noc_valid[u] && noc_ready) hs_cnt[u]++;
    end
    last_ready1 = req_ready[1];
    if (sb_on && noc_valid[1] && noc_ready) begin
      id = int'(grant_id[1]);
      check("sb_data", id, 64'(noc_data[1]), 64'(pkt(id, seq_out[id])));
      seq_out[id]++;
    end
    for (int u = 0; u < 2; u++) model_advance(u, pk[u]);
    @(posedge clk100);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("noc_valid", u, 64'(noc_valid[u]), 64'(m_valid[u]));
      check("noc_data",  u, 64'(noc_data[u]),  64'(m_data[u]));
      check("grant_id",  u, 64'(grant_id[u]),  64'(m_id[u]));
      check("done",      u, 64'(done[u]),      64'(m_done[u]));
`ifdef ARB_PKT_COUNT_EN
      check("pkt_count", u, 64'(pkt_count[u]), 64'(m_cnt[u]));
`endif
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    noc_ready = 1'b0;
    sb_on     = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    hs_cnt[0] = 0;
    hs_cnt[1] = 0;
  endtask

  task automatic set_all_data(input int seq);
    for (int k = 0; k < NUM_REQ; k++) req_data[k*TOTAL_W +: TOTAL_W] = pkt(k, seq);
  endtask

  initial begin
    int cyc;
    int total_out;
    bit timed_out;

    // Reset state.
    do_reset();
    for (int u = 0; u < 2; u++) begin
      check("rst_valid", u, 64'(noc_valid[u]), 64'(0));
      check("rst_data",  u, 64'(noc_data[u]),  64'(0));
      check("rst_grant", u, 64'(grant_id[u]),  64'(0));
      check("rst_done",  u, 64'(done[u]),      64'(0));
    end

    // All requesters valid, sink always ready: grants 0,1,2,3,... one per
    // cycle. The 10-packet arbiter stops after exactly ten handshakes.
    set_all_data(0);
    req_valid = '1;
    noc_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (i < 8) begin
        check("rr_grant", i, 64'(grant_id[1]),  64'(i % NUM_REQ));
        check("rr_valid", i, 64'(noc_valid[1]), 64'(1));
      end
    end
    check("quota_hs",    0, 64'(hs_cnt[0]),    64'(10));
    check("quota_done",  0, 64'(done[0]),      64'(1));
    check("quota_ready", 0, 64'(req_ready[0]), 64'(0));
    check("quota_done",  1, 64'(done[1]),      64'(0));

    // Backpressure: only requester 2 is valid and the sink stalls. The
    // captured packet must hold while no new packet is accepted.
    do_reset();
    req_data[2*TOTAL_W +: TOTAL_W] = pkt(2, 7);
    req_valid = 4'b0100;
    noc_ready = 1'b0;
    cycle();
    req_data[2*TOTAL_W +: TOTAL_W] = pkt(2, 8);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_data",  i, 64'(noc_data[1]),  64'(pkt(2, 7)));
      check("hold_ready", i, 64'(req_ready[1]), 64'(0));
    end
    noc_ready = 1'b1;
    cycle();
    check("b2b_data",  1, 64'(noc_data[1]),  64'(pkt(2, 8)));
    check("b2b_valid", 1, 64'(noc_valid[1]), 64'(1));
    req_valid = '0;
    cycle();
    check("drain_valid", 1, 64'(noc_valid[1]), 64'(0));

    // Wrap-around: grant requester 1 so the pointer moves to 2. With
    // requesters 1 and 3 valid, 3 must win before 1.
    do_reset();
    set_all_data(1);
    noc_ready = 1'b1;
    req_valid = 4'b0010;
    cycle();
    check("wrap_first",  1, 64'(grant_id[1]), 64'(1));
    req_valid = 4'b1010;
    cycle();
    check("wrap_second", 1, 64'(grant_id[1]), 64'(3));
    cycle();
    check("wrap_third",  1, 64'(grant_id[1]), 64'(1));

    // Reset while the slot holds a stalled packet.
    do_reset();
    set_all_data(2);
    req_valid = 4'b0001;
    noc_ready = 1'b0;
    cycle();
    check("full_valid", 1, 64'(noc_valid[1]), 64'(1));
    rst = 1'b1;
    cycle();
    check("midrst_valid", 1, 64'(noc_valid[1]), 64'(0));
    check("midrst_data",  1, 64'(noc_data[1]),  64'(0));
    check("midrst_done",  1, 64'(done[1]),      64'(0));
`ifdef ARB_PKT_COUNT_EN
    check("midrst_count", 1, 64'(pkt_count[1]), 64'(0));
`endif
    rst = 1'b0;
    req_valid = '0;

    // Random traffic on the 100-packet arbiter. Each requester offers a
    // numbered sequence, and the output must deliver every requester's
    // packets in order, exactly once.
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      seq_in[k]  = 0;
      seq_out[k] = 0;
    end
    sb_on     = 1'b1;
    timed_out = 1'b0;
    cyc       = 0;
    while (!(done[1] && !noc_valid[1])) begin
      if (cyc >= 5000) begin
        timed_out = 1'b1;
        break;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        req_valid[k] = ($urandom_range(0, 3) != 0);
        req_data[k*TOTAL_W +: TOTAL_W] = pkt(k, seq_in[k]);
      end
      noc_ready = ($urandom_range(0, 9) < 7);
      cycle();
      for (int k = 0; k < NUM_REQ; k++) begin
        if (last_ready1[k]) seq_in[k]++;
      end
      cyc++;
    end
    sb_on = 1'b0;
    check("rand_timeout", 1, 64'(timed_out), 64'(0));
    check("rand_hs",      1, 64'(hs_cnt[1]), 64'(100));
    total_out = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      total_out += seq_out[k];
      check("rand_perreq", k, 64'(seq_out[k]), 64'(seq_in[k]));
    end
    check("rand_total", 1, 64'(total_out), 64'(100));
    check("rand_done",  1, 64'(done[1]),   64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
